// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the write-back entry type.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency write-back results.
// The pointers carry an extra wrap bit so that full and empty can be told apart.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_queue.sv
// Register-file write-port arbiter: ALU results pass straight through, long-latency
// results are queued and retired on idle cycles, with a per-register pending scoreboard.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_wen,
    input  logic [ADDR_W-1:0]      alu_waddr,
    input  logic [DATA_W-1:0]      alu_wdata,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_waddr,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [ADDR_W-1:0]      lu_waddr,
    input  logic [DATA_W-1:0]      lu_wdata,
    output logic                   wen,
    output logic [ADDR_W-1:0]      waddr,
    output logic [DATA_W-1:0]      wdata,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic                   err
);

    localparam int NR = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t     fifo_din;
    entry_t     fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic [1:0] cnt     [NR];
    logic [1:0] cnt_nxt [NR];
    logic       err_set;

    assign lu_ready = !fifo_full;
    assign push     = lu_valid && !fifo_full;
    assign pop      = !alu_wen && !fifo_empty;
    assign fifo_din = '{waddr: lu_waddr, wdata: lu_wdata};

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        wen   = alu_wen || !fifo_empty;
        waddr = alu_waddr;
        wdata = alu_wdata;
        if (!alu_wen && !fifo_empty) begin
            waddr = fifo_head.waddr;
            wdata = fifo_head.wdata;
        end
    end

    // Retire is applied before issue, so a same-cycle issue and retire to one register cancel.
    always_comb begin
        err_set = alu_wen && busy[alu_waddr];
        for (int r = 0; r < NR; r++) begin
            busy[r]    = (cnt[r] != 2'd0);
            cnt_nxt[r] = cnt[r];
            if (pop && fifo_head.waddr == ADDR_W'(r)) begin
                if (cnt[r] == 2'd0) err_set = 1'b1;
                else                cnt_nxt[r] = cnt[r] - 2'd1;
            end
            if (issue_valid && issue_waddr == ADDR_W'(r)) begin
                if (cnt[r] == 2'd3)          err_set = 1'b1;
                if (cnt_nxt[r] != 2'd3)      cnt_nxt[r] = cnt_nxt[r] + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) cnt[r] <= 2'd0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < NR; r++) cnt[r] <= cnt_nxt[r];
            err <= err || err_set;
        end
    end

endmodule
